m65c02_reg_wr_sched: RTL and testbench
======================================

// Module: m65c02_reg_wr_sched
// PURPOSE
//  Write-port scheduler for the M65C02 register file (A, X, Y, P, S).
//  - Decodes microprogram write requests (Reg_WE/WSel) into one-hot registered write strobes.
//  - Shares the write port with a debug/monitor requester via a 4-phase req/ack handshake.
//  - Debug writes go into idle microcycles; a starvation counter forces a one-cycle CPU stall.
//  - Sits between the microsequencer/ALU and the register file.
// PARAMETERS
//  STARVE_MAX  8  busy CPU cycles a debug request waits before Stall is forced (1..255)
// PORTS
//  Clk        in   1  system clock; all state changes on rising edge
//  Rst        in   1  synchronous, active-high reset
//  Rdy        in   1  microcycle advance; CPU write inputs are sampled only when 1
//  Reg_WE     in   3  microprogram register write-enable field
//  WSel       in   3  instruction-decoder write select, used when Reg_WE==3'b100
//  ALU_DO     in   8  ALU result, CPU write data
//  Dbg_Req    in   1  debug write request (level); Dbg_Sel/Dbg_DI stable while high
//  Dbg_Sel    in   3  debug target: 0 A, 1 X, 2 Y, 3 P, 4 S, 5-7 illegal
//  Dbg_DI     in   8  debug write data
//  Dbg_Ack    out  1  debug handshake ack; held until Dbg_Req falls
//  Dbg_Err    out  1  qualifies Dbg_Ack: illegal Dbg_Sel, no write done
//  Stall      out  1  combinational; forces microsequencer to hold (Rdy low) this cycle
//  WE_A       out  1  register write strobes, registered, 1-cycle pulses
//  WE_X       out  1
//  WE_Y       out  1
//  WE_P       out  1
//  WE_S       out  1
//  WrData     out  8  data accompanying WE_*
//  WrSrc      out  1  0 = CPU write, 1 = debug write
// BEHAVIOUR
//  Reset: every output 0, FSM in IDLE, starve counter 0. Reset mid-handshake aborts
//   with no write; the requester must drop and re-raise Dbg_Req.
//  CPU decode (cpu_sel), {A,X,Y,P,S}:
//   Reg_WE 000/100-with-WSel-000,100/111 -> none
//   Reg_WE 001 -> A+P;  010 -> X+P;  011 -> Y+P;  101 -> S;  110 -> P
//   Reg_WE 100 uses WSel: 001 A+P, 010 X+P, 011 Y+P, 101 S, 110 P, 111 P, others none
//  CPU latency: edge N samples Rdy=1 with cpu_sel!=0, so WE_* = cpu_sel, WrData = ALU_DO,
//   WrSrc=0 during cycle N+1 only. Rdy=0 -> no strobe.
//  Debug writes affect only the named register, with no implied P write.
//  FSM states:
//   IDLE -> WAIT on Dbg_Req with legal Dbg_Sel.
//   IDLE -> HOLD on Dbg_Req with illegal Dbg_Sel; Dbg_Err=1, no write.
//   WAIT, free slot (Rdy & cpu_sel==0): issue the debug write and go to HOLD. Counter cleared.
//   WAIT, slot busy: counter +1, saturating at STARVE_MAX.
//   WAIT, counter==STARVE_MAX: Stall=1 combinationally, CPU sample masked, debug write
//    issued at that edge, go to HOLD.
//   HOLD: Dbg_Ack=1, asserted from the write-strobe cycle. Dbg_Err is held with it.
//   HOLD -> IDLE when Dbg_Req=0; Ack/Err clear on the next edge. Counter cleared.
//  Debug write output: WE_<Dbg_Sel>=1, WrData=Dbg_DI, WrSrc=1 for exactly one cycle.
//  Priority: a CPU write always wins a non-forced slot. CPU and debug strobes never occur
//   in the same cycle.
//  Dbg_Req dropping in WAIT (protocol violation): return to IDLE, no write.
//  Stall is 0 in IDLE and HOLD.
// STRUCTURE
//  m65c02_pkg holds:
//   - Reg_WE encodings (RWE_NONE, RWE_A, RWE_X, RWE_Y, RWE_WSEL, RWE_S, RWE_P)
//   - WSel encodings
//   - debug register indices (DBG_A..DBG_S)
//   - FSM state constants
//  Sub-module m65c02_wr_decode: combinational Reg_WE/WSel -> 5-bit cpu_sel.
//  This module holds the FSM, starve counter and output registers.
// TESTING
//  T1: Reg_WE=001, Rdy=1, ALU_DO=8'h5A -> next cycle WE_A=WE_P=1, WrData=5A, WrSrc=0,
//      one cycle only.
//  T2: Reg_WE=100 for each WSel 0..7 -> strobes match the table (e.g. 111 -> WE_P only).
//      Rdy=0 -> none.
//  T3: Reg_WE=000, Dbg_Req=1, Dbg_Sel=4, Dbg_DI=FF -> one cycle later WE_S=1, WrData=FF,
//      WrSrc=1, Dbg_Ack=1. Ack clears 1 cycle after Req falls.
//  T4: continuous CPU writes, Dbg_Req=1, Dbg_Sel=1 -> Stall=1 on cycle STARVE_MAX (8)
//      after WAIT entry. Debug WE_X is issued and the CPU write of that cycle is dropped.
//  T5: Dbg_Sel=6 -> Dbg_Ack=Dbg_Err=1, no WE_* pulse, Stall never asserted.
//  T6: Rst=1 during WAIT and during HOLD -> all outputs 0 next edge. Re-raised request completes normally.

Source files
------------

// File: rtl/m65c02_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : m65c02_pkg
//  Brief    : Shared encodings for the M65C02 register-file write scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package m65c02_pkg;

    // Microprogram Reg_WE field
    localparam logic [2:0] RWE_NONE = 3'b000;
    localparam logic [2:0] RWE_A    = 3'b001;
    localparam logic [2:0] RWE_X    = 3'b010;
    localparam logic [2:0] RWE_Y    = 3'b011;
    localparam logic [2:0] RWE_WSEL = 3'b100;
    localparam logic [2:0] RWE_S    = 3'b101;
    localparam logic [2:0] RWE_P    = 3'b110;

    // Instruction-decoder WSel field
    localparam logic [2:0] WSEL_NONE = 3'b000;
    localparam logic [2:0] WSEL_A    = 3'b001;
    localparam logic [2:0] WSEL_X    = 3'b010;
    localparam logic [2:0] WSEL_Y    = 3'b011;
    localparam logic [2:0] WSEL_S    = 3'b101;
    localparam logic [2:0] WSEL_P    = 3'b110;
    localparam logic [2:0] WSEL_P2   = 3'b111;

    // Debug register indices
    localparam logic [2:0] DBG_A = 3'd0;
    localparam logic [2:0] DBG_X = 3'd1;
    localparam logic [2:0] DBG_Y = 3'd2;
    localparam logic [2:0] DBG_P = 3'd3;
    localparam logic [2:0] DBG_S = 3'd4;

    // Strobe masks, bit order {A, X, Y, P, S}
    localparam logic [4:0] SEL_NONE = 5'b00000;
    localparam logic [4:0] SEL_AP   = 5'b10010;
    localparam logic [4:0] SEL_XP   = 5'b01010;
    localparam logic [4:0] SEL_YP   = 5'b00110;
    localparam logic [4:0] SEL_P    = 5'b00010;
    localparam logic [4:0] SEL_S    = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } dbgState_t;

    // Debug writes touch only the named register, never an implied P
    function automatic logic [4:0] dbgOneHot(input logic [2:0] sel);
        logic [4:0] m;
        m = SEL_NONE;
        case (sel)
            DBG_A:   m = 5'b10000;
            DBG_X:   m = 5'b01000;
            DBG_Y:   m = 5'b00100;
            DBG_P:   m = 5'b00010;
            DBG_S:   m = 5'b00001;
            default: m = SEL_NONE;
        endcase
        return m;
    endfunction

    function automatic logic dbgLegal(input logic [2:0] sel);
        return (sel <= DBG_S);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m65c02_reg_wr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : m65c02_reg_wr_sched_if
//  Brief    : Debug/monitor write-port handshake (4-phase req/ack).
//  Revision : 1.0 - initial release
// ============================================================================
interface m65c02_reg_wr_sched_if;
    logic       Dbg_Req;
    logic [2:0] Dbg_Sel;
    logic [7:0] Dbg_DI;
    logic       Dbg_Ack;
    logic       Dbg_Err;

    modport master (output Dbg_Req, Dbg_Sel, Dbg_DI, input Dbg_Ack, Dbg_Err);
    modport slave  (input Dbg_Req, Dbg_Sel, Dbg_DI, output Dbg_Ack, Dbg_Err);
endinterface
`default_nettype wire

// File: rtl/m65c02_wr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : m65c02_wr_decode
//  Brief    : Combinational Reg_WE/WSel decode to {A,X,Y,P,S} write select.
//  Revision : 1.0 - initial release
// ============================================================================
module m65c02_wr_decode
    import m65c02_pkg::*;
(
    input  wire logic [2:0] Reg_WE,
    input  wire logic [2:0] WSel,
    output logic      [4:0] CpuSel
);

    logic [4:0] w_wselDec;

    always_comb begin
        w_wselDec = SEL_NONE;
        case (WSel)
            WSEL_A:            w_wselDec = SEL_AP;
            WSEL_X:            w_wselDec = SEL_XP;
            WSEL_Y:            w_wselDec = SEL_YP;
            WSEL_S:            w_wselDec = SEL_S;
            WSEL_P, WSEL_P2:   w_wselDec = SEL_P;
            WSEL_NONE:         w_wselDec = SEL_NONE;
            default:           w_wselDec = SEL_NONE;
        endcase
    end

    always_comb begin
        CpuSel = SEL_NONE;
        case (Reg_WE)
            RWE_A:    CpuSel = SEL_AP;
            RWE_X:    CpuSel = SEL_XP;
            RWE_Y:    CpuSel = SEL_YP;
            RWE_WSEL: CpuSel = w_wselDec;
            RWE_S:    CpuSel = SEL_S;
            RWE_P:    CpuSel = SEL_P;
            RWE_NONE: CpuSel = SEL_NONE;
            default:  CpuSel = SEL_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m65c02_reg_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : m65c02_reg_wr_sched
//  Brief    : Register-file write-port scheduler sharing CPU and debug writes.
//  Revision : 1.0 - initial release
// ============================================================================
module m65c02_reg_wr_sched
    import m65c02_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  wire logic       Clk,
    input  wire logic       Rst,
    input  wire logic       Rdy,
    input  wire logic [2:0] Reg_WE,
    input  wire logic [2:0] WSel,
    input  wire logic [7:0] ALU_DO,
    m65c02_reg_wr_sched_if.slave dbg,
    output logic            Stall,
    output logic            WE_A,
    output logic            WE_X,
    output logic            WE_Y,
    output logic            WE_P,
    output logic            WE_S,
    output logic      [7:0] WrData,
    output logic            WrSrc
);

    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_MAX);

    dbgState_t  r_state, w_stateNxt;
    logic [7:0] r_starve, w_starveNxt;
    logic       r_err, w_errNxt;
    logic [4:0] r_we, w_weNxt;
    logic [7:0] r_wrData, w_wrDataNxt;
    logic       r_wrSrc, w_wrSrcNxt;

    logic [4:0] w_cpuSel;
    logic       w_force;
    logic       w_dbgIssue;

    m65c02_wr_decode u_decode (
        .Reg_WE (Reg_WE),
        .WSel   (WSel),
        .CpuSel (w_cpuSel)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_starve <= 8'd0;
            r_err    <= 1'b0;
            r_we     <= SEL_NONE;
            r_wrData <= 8'd0;
            r_wrSrc  <= 1'b0;
        end else begin
            r_state  <= w_stateNxt;
            r_starve <= w_starveNxt;
            r_err    <= w_errNxt;
            r_we     <= w_weNxt;
            r_wrData <= w_wrDataNxt;
            r_wrSrc  <= w_wrSrcNxt;
        end
    end

    always_comb begin
        w_stateNxt  = r_state;
        w_starveNxt = r_starve;
        w_errNxt    = r_err;
        w_force     = 1'b0;
        w_dbgIssue  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_starveNxt = 8'd0;
                if (dbg.Dbg_Req) begin
                    if (dbgLegal(dbg.Dbg_Sel)) begin
                        w_stateNxt = ST_WAIT;
                    end else begin
                        w_stateNxt = ST_HOLD;
                        w_errNxt   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_force = dbg.Dbg_Req && (r_starve == c_STARVE_MAX);
                if (!dbg.Dbg_Req) begin
                    w_stateNxt  = ST_IDLE;
                    w_starveNxt = 8'd0;
                end else if (w_force || (Rdy && (w_cpuSel == SEL_NONE))) begin
                    w_dbgIssue  = 1'b1;
                    w_stateNxt  = ST_HOLD;
                    w_starveNxt = 8'd0;
                end else if (r_starve != c_STARVE_MAX) begin
                    w_starveNxt = r_starve + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!dbg.Dbg_Req) begin
                    w_stateNxt  = ST_IDLE;
                    w_errNxt    = 1'b0;
                    w_starveNxt = 8'd0;
                end
            end
            default: begin
                w_stateNxt  = ST_IDLE;
                w_starveNxt = 8'd0;
                w_errNxt    = 1'b0;
            end
        endcase
    end

    // A forced debug slot masks the CPU sample, so the two strobes never collide
    always_comb begin
        w_weNxt     = SEL_NONE;
        w_wrDataNxt = 8'd0;
        w_wrSrcNxt  = 1'b0;
        if (w_dbgIssue) begin
            w_weNxt     = dbgOneHot(dbg.Dbg_Sel);
            w_wrDataNxt = dbg.Dbg_DI;
            w_wrSrcNxt  = 1'b1;
        end else if (Rdy && !w_force && (w_cpuSel != SEL_NONE)) begin
            w_weNxt     = w_cpuSel;
            w_wrDataNxt = ALU_DO;
        end
    end

    assign Stall       = w_force;
    assign dbg.Dbg_Ack = (r_state == ST_HOLD);
    assign dbg.Dbg_Err = r_err;
    assign {WE_A, WE_X, WE_Y, WE_P, WE_S} = r_we;
    assign WrData      = r_wrData;
    assign WrSrc       = r_wrSrc;

endmodule
`default_nettype wire

// File: tb/tb_m65c02_reg_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m65c02_reg_wr_sched
//  Brief    : Directed vector bench for the register write scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m65c02_reg_wr_sched;

    logic       Clk;
    logic       Rst;
    logic       Rdy;
    logic [2:0] Reg_WE;
    logic [2:0] WSel;
    logic [7:0] ALU_DO;
    logic       Stall, WE_A, WE_X, WE_Y, WE_P, WE_S, WrSrc;
    logic [7:0] WrData;
    logic [4:0] we;

    int nCmp = 0;
    int nErr = 0;

    m65c02_reg_wr_sched_if dbg ();

    m65c02_reg_wr_sched #(.STARVE_MAX(8)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Rdy    (Rdy),
        .Reg_WE (Reg_WE),
        .WSel   (WSel),
        .ALU_DO (ALU_DO),
        .dbg    (dbg),
        .Stall  (Stall),
        .WE_A   (WE_A),
        .WE_X   (WE_X),
        .WE_Y   (WE_Y),
        .WE_P   (WE_P),
        .WE_S   (WE_S),
        .WrData (WrData),
        .WrSrc  (WrSrc)
    );

    assign we = {WE_A, WE_X, WE_Y, WE_P, WE_S};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rdy;
        logic [2:0] regWe;
        logic [2:0] wsel;
        logic [7:0] alu;
        logic [4:0] expWe;
    } vec_t;

    vec_t vecs [18];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chkOut(input string name, input logic [4:0] eWe, input logic [7:0] eData,
                          input logic eSrc, input logic eAck, input logic eErr);
        chk({name, "_we"},   32'(we),          32'(eWe));
        chk({name, "_data"}, 32'(WrData),      32'(eData));
        chk({name, "_src"},  32'(WrSrc),       32'(eSrc));
        chk({name, "_ack"},  32'(dbg.Dbg_Ack), 32'(eAck));
        chk({name, "_err"},  32'(dbg.Dbg_Err), 32'(eErr));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b001, 3'b000, 8'h5A, 5'b10010};
        vecs[1]  = '{1'b1, 3'b010, 3'b000, 8'h11, 5'b01010};
        vecs[2]  = '{1'b1, 3'b011, 3'b000, 8'h22, 5'b00110};
        vecs[3]  = '{1'b1, 3'b101, 3'b000, 8'h33, 5'b00001};
        vecs[4]  = '{1'b1, 3'b110, 3'b000, 8'h44, 5'b00010};
        vecs[5]  = '{1'b1, 3'b111, 3'b000, 8'h55, 5'b00000};
        vecs[6]  = '{1'b1, 3'b000, 3'b111, 8'h66, 5'b00000};
        vecs[7]  = '{1'b1, 3'b100, 3'b000, 8'h70, 5'b00000};
        vecs[8]  = '{1'b1, 3'b100, 3'b001, 8'h71, 5'b10010};
        vecs[9]  = '{1'b1, 3'b100, 3'b010, 8'h72, 5'b01010};
        vecs[10] = '{1'b1, 3'b100, 3'b011, 8'h73, 5'b00110};
        vecs[11] = '{1'b1, 3'b100, 3'b100, 8'h74, 5'b00000};
        vecs[12] = '{1'b1, 3'b100, 3'b101, 8'h75, 5'b00001};
        vecs[13] = '{1'b1, 3'b100, 3'b110, 8'h76, 5'b00010};
        vecs[14] = '{1'b1, 3'b100, 3'b111, 8'h77, 5'b00010};
        vecs[15] = '{1'b0, 3'b001, 3'b000, 8'h78, 5'b00000};
        vecs[16] = '{1'b0, 3'b100, 3'b111, 8'h79, 5'b00000};
        vecs[17] = '{1'b1, 3'b000, 3'b000, 8'h7A, 5'b00000};

        Rst = 1'b1; Rdy = 1'b1; Reg_WE = 3'b000; WSel = 3'b000; ALU_DO = 8'h00;
        dbg.Dbg_Req = 1'b0; dbg.Dbg_Sel = 3'd0; dbg.Dbg_DI = 8'h00;
        tick(); tick();
        chkOut("reset", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_stall", 32'(Stall), 32'd0);
        Rst = 1'b0;

        // CPU decode table, including Rdy=0 suppression
        for (int i = 0; i < 18; i++) begin
            Rdy = vecs[i].rdy; Reg_WE = vecs[i].regWe; WSel = vecs[i].wsel; ALU_DO = vecs[i].alu;
            tick();
            chk($sformatf("dec%0d_we", i), 32'(we), 32'(vecs[i].expWe));
            chk($sformatf("dec%0d_data", i), 32'(WrData),
                (vecs[i].expWe != 5'b0) ? 32'(vecs[i].alu) : 32'h0);
            chk($sformatf("dec%0d_src", i), 32'(WrSrc), 32'd0);
        end

        // T1: single pulse
        Rdy = 1'b1; Reg_WE = 3'b001; ALU_DO = 8'h5A;
        tick();
        chkOut("t1_hit", 5'b10010, 8'h5A, 1'b0, 1'b0, 1'b0);
        Reg_WE = 3'b000;
        tick();
        chkOut("t1_after", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // T3: debug write into idle slots
        dbg.Dbg_Req = 1'b1; dbg.Dbg_Sel = 3'd4; dbg.Dbg_DI = 8'hFF;
        tick();
        chkOut("t3_wait", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t3_stall", 32'(Stall), 32'd0);
        tick();
        chkOut("t3_wr", 5'b00001, 8'hFF, 1'b1, 1'b1, 1'b0);
        tick();
        chkOut("t3_hold", 5'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        dbg.Dbg_Req = 1'b0;
        tick();
        chkOut("t3_rel", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // T4: starvation forces a stall on the 8th busy cycle
        Reg_WE = 3'b001; ALU_DO = 8'hA5;
        dbg.Dbg_Req = 1'b1; dbg.Dbg_Sel = 3'd1; dbg.Dbg_DI = 8'h3C;
        tick();
        chkOut("t4_entry", 5'b10010, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4_nostall%0d", k), 32'(Stall), 32'd0);
            tick();
            chkOut($sformatf("t4_cpu%0d", k), 5'b10010, 8'hA5, 1'b0, 1'b0, 1'b0);
        end
        chk("t4_stall", 32'(Stall), 32'd1);
        tick();
        chkOut("t4_forced", 5'b01000, 8'h3C, 1'b1, 1'b1, 1'b0);
        chk("t4_stall_hold", 32'(Stall), 32'd0);
        dbg.Dbg_Req = 1'b0; Reg_WE = 3'b000;
        tick();
        chkOut("t4_rel", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // T5: illegal target
        dbg.Dbg_Req = 1'b1; dbg.Dbg_Sel = 3'd6; dbg.Dbg_DI = 8'h81;
        chk("t5_stall0", 32'(Stall), 32'd0);
        tick();
        chkOut("t5_err", 5'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("t5_stall1", 32'(Stall), 32'd0);
        tick();
        chkOut("t5_errhold", 5'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        dbg.Dbg_Req = 1'b0;
        tick();
        chkOut("t5_rel", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // T6: reset during WAIT, then during HOLD
        Reg_WE = 3'b001; ALU_DO = 8'h42;
        dbg.Dbg_Req = 1'b1; dbg.Dbg_Sel = 3'd2; dbg.Dbg_DI = 8'h99;
        tick();
        chkOut("t6_wait", 5'b10010, 8'h42, 1'b0, 1'b0, 1'b0);
        Rst = 1'b1; dbg.Dbg_Req = 1'b0;
        tick();
        chkOut("t6_rstw", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_rstw_stall", 32'(Stall), 32'd0);
        Rst = 1'b0; Reg_WE = 3'b000; dbg.Dbg_Req = 1'b1;
        tick();
        tick();
        chkOut("t6_redo", 5'b00100, 8'h99, 1'b1, 1'b1, 1'b0);
        Rst = 1'b1; dbg.Dbg_Req = 1'b0;
        tick();
        chkOut("t6_rsth", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        Rst = 1'b0; dbg.Dbg_Req = 1'b1; dbg.Dbg_Sel = 3'd0; dbg.Dbg_DI = 8'h12;
        tick();
        tick();
        chkOut("t6_redo2", 5'b10000, 8'h12, 1'b1, 1'b1, 1'b0);
        dbg.Dbg_Req = 1'b0;
        tick();
        chkOut("t6_rel", 5'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
